// File: rtl/parser_pkg.sv
// Shared definitions for the stream packet builder/parser pair.
// Holds the packet FSM state encoding, the fixed field sizes, the captured
// per-packet descriptor and the little-endian byte-swap helpers.
package parser_pkg;

  localparam int unsigned NUM_STREAMS       = 32;
  localparam int unsigned IDX_W             = 5;
  localparam int unsigned MAX_PAYLOAD_BYTES = 37;
  localparam int unsigned HDR_BYTES         = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned ID_W              = 16;
  localparam int unsigned LEN_W             = 6;
  localparam int unsigned SEQ_W             = 32;
  localparam int unsigned TOTAL_W           = 16;
  localparam int unsigned PAYLOAD_W         = 8 * MAX_PAYLOAD_BYTES;
  localparam int unsigned MAX_WORDS         = 10;
  // Payload staging is padded to a whole number of words so the last word
  // can always be taken from the low 32 bits.
  localparam int unsigned PAD_W             = MAX_WORDS * WORD_W;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEQ  = 2'd2,
    ST_DATA = 2'd3
  } state_e;

  // Per-packet context captured at acceptance.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SEQ_W-1:0] seq;
  } pkt_desc_t;

  function automatic logic [15:0] bswap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/tx_seq_table.sv
// Per-stream transmit sequence number table.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (all entries -> 0)
//   rd_idx_i     : combinational read index
//   rd_seq_c     : current sequence number of entry rd_idx_i (combinational)
//   inc_en_i     : write strobe
//   inc_idx_i    : entry to update
//   inc_base_i   : entry is written with inc_base_i + 1
module tx_seq_table
  import parser_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [SEQ_W-1:0] rd_seq_c,
  input  logic             inc_en_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic [SEQ_W-1:0] inc_base_i
);

  logic [SEQ_W-1:0] seqs_q [NUM_STREAMS];

  // Sequence storage; wraps naturally modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STREAMS); i++) begin
        seqs_q[i] <= '0;
      end
    end else if (inc_en_i) begin
      seqs_q[inc_idx_i] <= inc_base_i + SEQ_W'(1);
    end
  end

  assign rd_seq_c = seqs_q[rd_idx_i];

endmodule

// File: rtl/pkt_seq_builder.sv
// Transmit packet builder: accepts one payload with stream ID and length,
// stamps it with the stream's next sequence number and serialises it as
// HDR word, SEQ word, then ceil(len/4) payload words on a valid/ready/last
// 32-bit stream. Illegal lengths (0 or >37) are dropped with an errDrop pulse.
// Optional feature macro TX_SEQ_SKIP_EN adds input skipSeq: an accepted
// payload with skipSeq=1 is sent with seq+1 and the table advances by 2.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   payloadIn/payloadLen/streamId   : payload bytes (byte k at [8k+:8]), length, ID
//   payloadIn_val/payloadIn_ready   : input handshake
//   dataOut/dataOut_val/_ready/_last: output word stream, first wire byte [31:24]
//   errDrop                         : one-cycle illegal-length drop pulse
module pkt_seq_builder
  import parser_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] payloadIn,
  input  logic [LEN_W-1:0]     payloadLen,
  input  logic [ID_W-1:0]      streamId,
  input  logic                 payloadIn_val,
`ifdef TX_SEQ_SKIP_EN
  input  logic                 skipSeq,
`endif
  output logic                 payloadIn_ready,
  output logic [WORD_W-1:0]    dataOut,
  output logic                 dataOut_val,
  input  logic                 dataOut_ready,
  output logic                 dataOut_last,
  output logic                 errDrop
);

  state_e             state_q, state_d;
  pkt_desc_t          desc_q, desc_d;
  logic [PAD_W-1:0]   payload_q, payload_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ready_q, ready_d;
  logic [WORD_W-1:0]  dout_q, dout_d;
  logic               val_q, val_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic [SEQ_W-1:0]   rd_seq_c;
  logic               inc_en_c;
  logic               len_ok_c;
  logic               skip_c;
  logic [PAD_W-1:0]   masked_c;
  logic [CNT_W-1:0]   nwords_c;
  logic [TOTAL_W-1:0] total_c;

  tx_seq_table u_seq_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (streamId[IDX_W-1:0]),
    .rd_seq_c   (rd_seq_c),
    .inc_en_i   (inc_en_c),
    .inc_idx_i  (desc_q.idx),
    .inc_base_i (desc_q.seq)
  );

`ifdef TX_SEQ_SKIP_EN
  assign skip_c = skipSeq;
`else
  assign skip_c = 1'b0;
`endif

  assign len_ok_c = (payloadLen != '0) && (payloadLen <= LEN_W'(MAX_PAYLOAD_BYTES));
  // Only meaningful for legal lengths (<= 37), so the 6-bit sum cannot overflow.
  assign nwords_c = CNT_W'((payloadLen + LEN_W'(3)) >> 2);
  assign total_c  = TOTAL_W'(payloadLen) + TOTAL_W'(HDR_BYTES);

  // Zero bytes at and beyond len so the final word pads with zeros.
  always_comb begin
    masked_c = '0;
    for (int k = 0; k < int'(MAX_PAYLOAD_BYTES); k++) begin
      if (k < int'(payloadLen)) begin
        masked_c[8*k +: 8] = payloadIn[8*k +: 8];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    payload_d = payload_q;
    rem_d     = rem_q;
    ready_d   = ready_q;
    dout_d    = dout_q;
    val_d     = val_q;
    last_d    = last_q;
    err_d     = 1'b0;
    inc_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (payloadIn_val && ready_q) begin
          if (len_ok_c) begin
            desc_d.idx = streamId[IDX_W-1:0];
            desc_d.seq = rd_seq_c + SEQ_W'(skip_c);
            payload_d  = masked_c;
            rem_d      = nwords_c;
            dout_d     = {bswap16(total_c), bswap16(streamId)};
            val_d      = 1'b1;
            last_d     = 1'b0;
            ready_d    = 1'b0;
            state_d    = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (dataOut_ready) begin
          dout_d  = bswap32(desc_q.seq);
          state_d = ST_SEQ;
        end
      end

      ST_SEQ: begin
        // Payload words are always taken from the low word, then shifted out.
        if (dataOut_ready) begin
          dout_d    = bswap32(payload_q[WORD_W-1:0]);
          payload_d = payload_q >> WORD_W;
          rem_d     = rem_q - CNT_W'(1);
          last_d    = (rem_q == CNT_W'(1));
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (dataOut_ready) begin
          if (last_q) begin
            dout_d   = '0;
            val_d    = 1'b0;
            last_d   = 1'b0;
            ready_d  = 1'b1;
            inc_en_c = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            dout_d    = bswap32(payload_q[WORD_W-1:0]);
            payload_d = payload_q >> WORD_W;
            rem_d     = rem_q - CNT_W'(1);
            last_d    = (rem_q == CNT_W'(1));
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      desc_q    <= '0;
      payload_q <= '0;
      rem_q     <= '0;
      ready_q   <= 1'b1;
      dout_q    <= '0;
      val_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      payload_q <= payload_d;
      rem_q     <= rem_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
      val_q     <= val_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign payloadIn_ready = ready_q;
  assign dataOut         = dout_q;
  assign dataOut_val     = val_q;
  assign dataOut_last    = last_q;
  assign errDrop         = err_q;

endmodule

// File: tb/tb_pkt_seq_builder.sv
// Directed self-checking bench for pkt_seq_builder.
module tb_pkt_seq_builder;

  logic         clk;
  logic         reset;
  logic [295:0] payloadIn;
  logic [5:0]   payloadLen;
  logic [15:0]  streamId;
  logic         payloadIn_val;
  logic         payloadIn_ready;
  logic [31:0]  dataOut;
  logic         dataOut_val;
  logic         dataOut_ready;
  logic         dataOut_last;
  logic         errDrop;
`ifdef TX_SEQ_SKIP_EN
  logic         skipSeq;
`endif

  int n_vec;
  int n_err;
  logic [31:0] exp_w [16];

  pkt_seq_builder dut (
    .clk             (clk),
    .reset           (reset),
    .payloadIn       (payloadIn),
    .payloadLen      (payloadLen),
    .streamId        (streamId),
    .payloadIn_val   (payloadIn_val),
`ifdef TX_SEQ_SKIP_EN
    .skipSeq         (skipSeq),
`endif
    .payloadIn_ready (payloadIn_ready),
    .dataOut         (dataOut),
    .dataOut_val     (dataOut_val),
    .dataOut_ready   (dataOut_ready),
    .dataOut_last    (dataOut_last),
    .errDrop         (errDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Presents one payload (bytes 01,02,... in every position) for one accepting edge.
  task automatic send(input logic [15:0] id, input logic [5:0] len);
    payloadIn = '0;
    for (int k = 0; k < 37; k++) payloadIn[8*k +: 8] = 8'(k + 1);
    payloadLen    = len;
    streamId      = id;
    payloadIn_val = 1'b1;
    chk("in_ready", 32'(payloadIn_ready), 32'd1);
    @(posedge clk); #1;
    payloadIn_val = 1'b0;
  endtask

  // Drains n words, comparing against exp_w; optionally randomises ready.
  task automatic collect(input int n, input bit rnd);
    int          idx;
    int          budget;
    logic [31:0] held;
    logic        held_last;
    bit          stalled;
    idx = 0;
    budget = 0;
    held = '0;
    held_last = 1'b0;
    while (idx < n && budget < 400) begin
      dataOut_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (dataOut_val && dataOut_ready) begin
        chk("word", dataOut, exp_w[idx]);
        chk("last", 32'(dataOut_last), 32'(idx == n - 1));
        idx++;
      end else if (dataOut_val) begin
        held      = dataOut;
        held_last = dataOut_last;
        stalled   = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
      if (stalled) begin
        chk("hold_word", dataOut, held);
        chk("hold_last", 32'(dataOut_last), 32'(held_last));
      end
    end
    chk("timeout_words", 32'(idx), 32'(n));
    dataOut_ready = 1'b1;
    chk("done_val", 32'(dataOut_val), 32'd0);
    chk("ready_back", 32'(payloadIn_ready), 32'd1);
  endtask

  task automatic set_len10(input logic [31:0] hdr, input logic [31:0] seq);
    exp_w[0] = hdr;
    exp_w[1] = seq;
    exp_w[2] = 32'h01020304;
    exp_w[3] = 32'h05060708;
    exp_w[4] = 32'h090A0000;
  endtask

  task automatic set_len37(input logic [31:0] seq);
    exp_w[0] = 32'h2D000700;
    exp_w[1] = seq;
    for (int j = 0; j < 9; j++)
      exp_w[2 + j] = {8'(4*j + 1), 8'(4*j + 2), 8'(4*j + 3), 8'(4*j + 4)};
    exp_w[11] = 32'h25000000;
  endtask

  task automatic check_drop(input logic [5:0] len);
    send(16'd9, len);
    chk("err_pulse", 32'(errDrop), 32'd1);
    chk("err_noval", 32'(dataOut_val), 32'd0);
    @(posedge clk); #1;
    chk("err_clear", 32'(errDrop), 32'd0);
    chk("err_noval2", 32'(dataOut_val), 32'd0);
    chk("err_ready", 32'(payloadIn_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    payloadIn = '0;
    payloadLen = '0;
    streamId = '0;
    payloadIn_val = 1'b0;
    dataOut_ready = 1'b1;
`ifdef TX_SEQ_SKIP_EN
    skipSeq = 1'b0;
`endif
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(payloadIn_ready), 32'd1);
    chk("rst_dout", dataOut, 32'd0);
    chk("rst_val", 32'(dataOut_val), 32'd0);
    chk("rst_last", 32'(dataOut_last), 32'd0);
    chk("rst_err", 32'(errDrop), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Stream 5, len 10, first packet
    send(16'd5, 6'd10);
    chk("lat1_val", 32'(dataOut_val), 32'd1);
    chk("legal_noerr", 32'(errDrop), 32'd0);
    set_len10(32'h12000500, 32'h00000000);
    collect(5, 1'b0);

    // Stream 5 again, then a fresh stream 6
    send(16'd5, 6'd10);
    set_len10(32'h12000500, 32'h01000000);
    collect(5, 1'b0);
    send(16'd6, 6'd10);
    set_len10(32'h12000600, 32'h00000000);
    collect(5, 1'b0);

    // ID 0x0025 aliases onto entry 5 (seq 2) but sends the full ID
    send(16'h0025, 6'd4);
    exp_w[0] = 32'h0C002500;
    exp_w[1] = 32'h02000000;
    exp_w[2] = 32'h01020304;
    collect(3, 1'b0);

    // Maximum length, then the same with random backpressure
    send(16'd7, 6'd37);
    set_len37(32'h00000000);
    collect(12, 1'b0);
    send(16'd7, 6'd37);
    set_len37(32'h01000000);
    collect(12, 1'b1);

    // Illegal lengths dropped; stream 9 still starts at seq 0
    check_drop(6'd0);
    check_drop(6'd40);
    send(16'd9, 6'd4);
    exp_w[0] = 32'h0C000900;
    exp_w[1] = 32'h00000000;
    exp_w[2] = 32'h01020304;
    collect(3, 1'b0);

    // Reset mid-DATA
    send(16'd5, 6'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_data_word", dataOut, 32'h01020304);
    reset = 1'b1;
    #1;
    chk("arst_val", 32'(dataOut_val), 32'd0);
    chk("arst_dout", dataOut, 32'd0);
    chk("arst_last", 32'(dataOut_last), 32'd0);
    chk("arst_ready", 32'(payloadIn_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send(16'd5, 6'd10);
    set_len10(32'h12000500, 32'h00000000);
    collect(5, 1'b0);

`ifdef TX_SEQ_SKIP_EN
    skipSeq = 1'b1;
    send(16'd10, 6'd10);
    skipSeq = 1'b0;
    set_len10(32'h12000A00, 32'h01000000);
    collect(5, 1'b0);
    send(16'd10, 6'd10);
    set_len10(32'h12000A00, 32'h02000000);
    collect(5, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
